local_velocity_mac: RTL

LOCAL_VELOCITY_MAC -- requirements
Module: local_velocity_mac

---
 rtl/local_velocity_mac_pkg.sv | 19 +
 rtl/local_velocity_mac_mul_sat.sv | 39 +++
 rtl/local_velocity_mac.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/local_velocity_mac_pkg.sv
// Shared types and default parameters for the local velocity MAC.
// Holds the FSM state set and the default word/gain settings.
package local_velocity_mac_pkg;

  localparam int DATAWIDTH_N_DEF  = 32;
  localparam int FRACTIONAL_Q_DEF = 15;
  localparam int K_V_DEF          = 328;
  localparam int K_W_DEF          = 1638;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUM    = 3'd1,
    ST_MUL_VX = 3'd2,
    ST_MUL_VY = 3'd3,
    ST_MUL_WZ = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/local_velocity_mac_mul_sat.sv
// Signed fixed-point multiply, arithmetic right shift, and saturation.
// Ports: a (N+2 sum), k (N gain) in; y (N result), sat (clamped) out.
module fx_mul_sat #(
  parameter int DATAWIDTH_N  = 32,
  parameter int FRACTIONAL_Q = 15
) (
  input  logic signed [DATAWIDTH_N+1:0] a,
  input  logic signed [DATAWIDTH_N-1:0] k,
  output logic signed [DATAWIDTH_N-1:0] y,
  output logic                          sat
);

  localparam int PW = 2 * DATAWIDTH_N + 2;

  localparam logic signed [PW-1:0] MAX_V =
    {{(PW-DATAWIDTH_N+1){1'b0}}, {(DATAWIDTH_N-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V =
    {{(PW-DATAWIDTH_N+1){1'b1}}, {(DATAWIDTH_N-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shf;

  // PW bits hold any (N+2)x(N) signed product exactly.
  assign prod = PW'(a) * PW'(k);
  assign shf  = prod >>> FRACTIONAL_Q;

  always_comb begin
    y   = shf[DATAWIDTH_N-1:0];
    sat = 1'b0;
    if (shf > MAX_V) begin
      y   = MAX_V[DATAWIDTH_N-1:0];
      sat = 1'b1;
    end else if (shf < MIN_V) begin
      y   = MIN_V[DATAWIDTH_N-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/local_velocity_mac.sv
// Mecanum wheel speeds to local body velocity (vx, vy, wz) via one shared MAC.
// Ports: clock, async low reset, start, W1..W4 in; VX/VY/WZ, busy, done, sat out.
module local_velocity_mac
  import local_velocity_mac_pkg::*;
#(
  parameter int DATAWIDTH_N  = DATAWIDTH_N_DEF,
  parameter int FRACTIONAL_Q = FRACTIONAL_Q_DEF,
  parameter int K_V          = K_V_DEF,
  parameter int K_W          = K_W_DEF
) (
  input  logic                   LOCAL_VELOCITY_MAC_CLOCK_50,
  input  logic                   LOCAL_VELOCITY_MAC_Reset_InLow,
  input  logic                   LOCAL_VELOCITY_MAC_Start_In,
  input  logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_W1_InBus,
  input  logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_W2_InBus,
  input  logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_W3_InBus,
  input  logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_W4_InBus,
  output logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_VX_OutBus,
  output logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_VY_OutBus,
  output logic [DATAWIDTH_N-1:0] LOCAL_VELOCITY_MAC_WZ_OutBus,
  output logic                   LOCAL_VELOCITY_MAC_Busy_Out,
  output logic                   LOCAL_VELOCITY_MAC_Done_Out,
  output logic                   LOCAL_VELOCITY_MAC_Sat_Out
);

  localparam int SW = DATAWIDTH_N + 2;

  localparam logic signed [DATAWIDTH_N-1:0] KV = DATAWIDTH_N'(K_V);
  localparam logic signed [DATAWIDTH_N-1:0] KW = DATAWIDTH_N'(K_W);

  logic clk;
  logic rst_n;
  logic start;

  assign clk   = LOCAL_VELOCITY_MAC_CLOCK_50;
  assign rst_n = LOCAL_VELOCITY_MAC_Reset_InLow;
  assign start = LOCAL_VELOCITY_MAC_Start_In;

  state_t state;
  state_t state_nxt;

  logic signed [DATAWIDTH_N-1:0] w1_q;
  logic signed [DATAWIDTH_N-1:0] w2_q;
  logic signed [DATAWIDTH_N-1:0] w3_q;
  logic signed [DATAWIDTH_N-1:0] w4_q;

  logic signed [SW-1:0] e1;
  logic signed [SW-1:0] e2;
  logic signed [SW-1:0] e3;
  logic signed [SW-1:0] e4;

  logic signed [SW-1:0] sx;
  logic signed [SW-1:0] sy;
  logic signed [SW-1:0] sw;

  logic signed [SW-1:0]          mul_a;
  logic signed [DATAWIDTH_N-1:0] mul_k;
  logic signed [DATAWIDTH_N-1:0] mul_y;
  logic                          mul_sat;

  logic signed [DATAWIDTH_N-1:0] vx_st;
  logic signed [DATAWIDTH_N-1:0] vy_st;
  logic signed [DATAWIDTH_N-1:0] wz_st;
  logic                          sat_vx;
  logic                          sat_vy;
  logic                          sat_wz;

  assign e1 = SW'(w1_q);
  assign e2 = SW'(w2_q);
  assign e3 = SW'(w3_q);
  assign e4 = SW'(w4_q);

  assign LOCAL_VELOCITY_MAC_Busy_Out = (state != ST_IDLE);

  always_comb begin
    state_nxt = ST_IDLE;
    unique case (1'b1)
      state == ST_IDLE:   state_nxt = start ? ST_SUM : ST_IDLE;
      state == ST_SUM:    state_nxt = ST_MUL_VX;
      state == ST_MUL_VX: state_nxt = ST_MUL_VY;
      state == ST_MUL_VY: state_nxt = ST_MUL_WZ;
      state == ST_MUL_WZ: state_nxt = ST_DONE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_k = '0;
    unique case (1'b1)
      state == ST_MUL_VX: begin
        mul_a = sx;
        mul_k = KV;
      end
      state == ST_MUL_VY: begin
        mul_a = sy;
        mul_k = KV;
      end
      state == ST_MUL_WZ: begin
        mul_a = sw;
        mul_k = KW;
      end
      default: ;
    endcase
  end

  fx_mul_sat #(
    .DATAWIDTH_N  (DATAWIDTH_N),
    .FRACTIONAL_Q (FRACTIONAL_Q)
  ) u_mul (
    .a   (mul_a),
    .k   (mul_k),
    .y   (mul_y),
    .sat (mul_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      w1_q   <= '0;
      w2_q   <= '0;
      w3_q   <= '0;
      w4_q   <= '0;
      sx     <= '0;
      sy     <= '0;
      sw     <= '0;
      vx_st  <= '0;
      vy_st  <= '0;
      wz_st  <= '0;
      sat_vx <= 1'b0;
      sat_vy <= 1'b0;
      sat_wz <= 1'b0;
      LOCAL_VELOCITY_MAC_VX_OutBus <= '0;
      LOCAL_VELOCITY_MAC_VY_OutBus <= '0;
      LOCAL_VELOCITY_MAC_WZ_OutBus <= '0;
      LOCAL_VELOCITY_MAC_Done_Out  <= 1'b0;
      LOCAL_VELOCITY_MAC_Sat_Out   <= 1'b0;
    end else begin
      state <= state_nxt;
      LOCAL_VELOCITY_MAC_Done_Out <= 1'b0;
      unique case (1'b1)
        state == ST_IDLE: begin
          if (start) begin
            w1_q <= LOCAL_VELOCITY_MAC_W1_InBus;
            w2_q <= LOCAL_VELOCITY_MAC_W2_InBus;
            w3_q <= LOCAL_VELOCITY_MAC_W3_InBus;
            w4_q <= LOCAL_VELOCITY_MAC_W4_InBus;
          end
        end
        state == ST_SUM: begin
          sx <=  e1 + e2 + e3 + e4;
          sy <= -e1 + e2 + e3 - e4;
          sw <= -e1 + e2 - e3 + e4;
        end
        state == ST_MUL_VX: begin
          vx_st  <= mul_y;
          sat_vx <= mul_sat;
        end
        state == ST_MUL_VY: begin
          vy_st  <= mul_y;
          sat_vy <= mul_sat;
        end
        state == ST_MUL_WZ: begin
          wz_st  <= mul_y;
          sat_wz <= mul_sat;
        end
        state == ST_DONE: begin
          LOCAL_VELOCITY_MAC_VX_OutBus <= vx_st;
          LOCAL_VELOCITY_MAC_VY_OutBus <= vy_st;
          LOCAL_VELOCITY_MAC_WZ_OutBus <= wz_st;
          LOCAL_VELOCITY_MAC_Sat_Out   <= sat_vx | sat_vy | sat_wz;
          LOCAL_VELOCITY_MAC_Done_Out  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
